detect_timestamp_fifo: RTL and testbench

Downstream consumer of the serial pattern detector's Mealy `detect` pulse. Each pulse is stamped with a free-running cycle count and buffered in a small FIFO. Software or a downstream stage drains the FIFO over a valid/ready interface. A sticky overflow flag records any pulse lost to a full FIFO.

---
 rtl/detect_timestamp_fifo.sv | 97 +++++++++
 tb/tb_detect_timestamp_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/detect_timestamp_fifo.sv
// detect_timestamp_fifo
// Stamps each detector pulse with a free-running cycle count and queues the
// stamp in a small FIFO that is drained over a valid/ready interface.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   detect        - event pulse, sampled every cycle
//   ts_ready      - consumer accepts head entry (ignored while ts_valid=0)
//   ts_valid      - FIFO not empty
//   ts_data       - timestamp at FIFO head (don't-care while ts_valid=0)
//   count         - occupancy, 0..DEPTH
//   overflow      - sticky: a pulse was dropped on a full FIFO
//   clr_ovf       - clears overflow (a same-cycle drop wins)
//   drop_cnt      - saturating count of dropped pulses
//
// Optional feature macro: DETECT_TS_DROP_CNT_EN
//   defined     - drop_cnt is an 8-bit saturating drop counter
//   not defined - drop_cnt is tied to 0
module detect_timestamp_fifo #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     detect,
    input  logic                     ts_ready,
    input  logic                     clr_ovf,
    output logic                     ts_valid,
    output logic [TS_W-1:0]          ts_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    // Full/empty decisions use the registered count, so a pop in the same
    // cycle cannot make room for a pulse arriving on a full FIFO.
    assign full     = (count == CW'(DEPTH));
    assign push     = detect && !full;
    assign drop     = detect && full;
    assign ts_valid = (count != '0);
    assign pop      = ts_valid && ts_ready;
    assign ts_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            ts <= ts + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set has priority over clear.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    // Storage carries no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= ts;
    end

`ifdef DETECT_TS_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (clr_ovf)                drop_cnt <= 8'd1;
            else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (clr_ovf) begin
            drop_cnt <= '0;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_detect_timestamp_fifo.sv
module tb_detect_timestamp_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        detect = 1'b0, ts_ready = 1'b0, clr_ovf = 1'b0;
    logic        ts_valid, overflow;
    logic [15:0] ts_data;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    logic        detect4 = 1'b0, ready4 = 1'b0;
    logic        ts_valid4, overflow4;
    logic [3:0]  ts_data4;
    logic [3:0]  count4;
    logic [7:0]  drop_cnt4;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] m_ts;   // ts value the next rising edge will see

`ifdef DETECT_TS_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    detect_timestamp_fifo #(.TS_W(16), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .detect(detect), .ts_ready(ts_ready),
        .clr_ovf(clr_ovf), .ts_valid(ts_valid), .ts_data(ts_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt));

    detect_timestamp_fifo #(.TS_W(4), .DEPTH(8)) dut4 (
        .clk(clk), .rst(rst), .detect(detect4), .ts_ready(ready4),
        .clr_ovf(1'b0), .ts_valid(ts_valid4), .ts_data(ts_data4),
        .count(count4), .overflow(overflow4), .drop_cnt(drop_cnt4));

    // One clock: inputs set before the call are sampled at this edge.
    task automatic step();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        m_ts = r ? 16'd0 : m_ts + 16'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; detect = 0; ts_ready = 0; clr_ovf = 0; detect4 = 0; ready4 = 0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic wait_ts(input logic [15:0] t);
        for (int i = 0; i < 200 && m_ts != t; i++) step();
        n_cmp++;
        if (m_ts != t) begin n_bad++; $display("FAIL wait_ts got %0d exp %0d", m_ts, t); end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ts_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", ts_valid); end
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
        wait_ts(16'd5);
        detect = 1; step(); detect = 0;
        n_cmp++; if (ts_valid !== 1'b1) begin n_bad++; $display("FAIL cap_valid got %b exp 1", ts_valid); end
        n_cmp++; if (ts_data !== 16'd5) begin n_bad++; $display("FAIL cap_data got %0d exp 5", ts_data); end
        n_cmp++; if (count !== 4'd1) begin n_bad++; $display("FAIL cap_count got %0d exp 1", count); end
        // Reset mid-stream, with detect held high (must be ignored).
        rst = 1; detect = 1; step(); step();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL midrst_count got %0d exp 0", count); end
        n_cmp++; if (ts_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b exp 0", ts_valid); end
        detect = 0; rst = 0;
        step();
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL post_rst_count got %0d exp 0", count); end
    endtask

    task automatic test_fill_overflow();
        logic [15:0] s;
        do_reset();
        wait_ts(16'd20);
        detect = 1;
        repeat (10) step();
        detect = 0;
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d exp 8", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_ovf got %b exp 1", overflow); end
        n_cmp++; if (drop_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin n_bad++; $display("FAIL fill_drop got %0d exp %0d", drop_cnt, CNT_EN ? 2 : 0); end
        clr_ovf = 1; step(); clr_ovf = 0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got %b exp 0", overflow); end
        n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_drop got %0d exp 0", drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (ts_data !== 16'(20 + i)) begin n_bad++; $display("FAIL fill_entry%0d got %0d exp %0d", i, ts_data, 20 + i); end
            ts_ready = 1; step(); ts_ready = 0;
        end
        n_cmp++; if (ts_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b exp 0", ts_valid); end
        // Refill, then drop coincident with clr_ovf: set wins.
        s = m_ts;
        detect = 1; repeat (8) step();
        clr_ovf = 1; step(); clr_ovf = 0; detect = 0;
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL setwins_ovf got %b exp 1", overflow); end
        n_cmp++; if (drop_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin n_bad++; $display("FAIL setwins_drop got %0d exp %0d", drop_cnt, CNT_EN ? 1 : 0); end
        // Full: pop and pulse together -> pop happens, pulse dropped.
        ts_ready = 1; detect = 1; step(); ts_ready = 0; detect = 0;
        n_cmp++; if (count !== 4'd7) begin n_bad++; $display("FAIL fullpop_count got %0d exp 7", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fullpop_ovf got %b exp 1", overflow); end
        n_cmp++; if (ts_data !== s + 16'd1) begin n_bad++; $display("FAIL fullpop_head got %0d exp %0d", ts_data, s + 16'd1); end
        n_cmp++; if (drop_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin n_bad++; $display("FAIL fullpop_drop got %0d exp %0d", drop_cnt, CNT_EN ? 2 : 0); end
    endtask

    task automatic test_stream();
        do_reset();
        ts_ready = 1; detect = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++; if (count !== 4'd1 || ts_data !== m_ts - 16'd1) begin
                n_bad++; $display("FAIL stream%0d count %0d data %0d exp count 1 data %0d", i, count, ts_data, m_ts - 16'd1);
            end
        end
        detect = 0; step(); ts_ready = 0;
        n_cmp++; if (count !== 4'd0) begin n_bad++; $display("FAIL stream_end_count got %0d exp 0", count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stream_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp4 [8];
        do_reset();
        wait_ts(16'd14);
        detect4 = 1; repeat (4) step(); detect4 = 0;
        n_cmp++; if (count4 !== 4'd4) begin n_bad++; $display("FAIL wrap_count got %0d exp 4", count4); end
        exp4[0] = 4'd14; exp4[1] = 4'd15; exp4[2] = 4'd0; exp4[3] = 4'd1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ts_data4 !== exp4[i]) begin n_bad++; $display("FAIL wrap_ts%0d got %0d exp %0d", i, ts_data4, exp4[i]); end
            ready4 = 1; step(); ready4 = 0;
        end
        // Eight more entries push both pointers past the end of the array.
        detect4 = 1;
        for (int i = 0; i < 8; i++) begin exp4[i] = m_ts[3:0]; step(); end
        detect4 = 0;
        n_cmp++; if (count4 !== 4'd8) begin n_bad++; $display("FAIL wrap_full got %0d exp 8", count4); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (ts_data4 !== exp4[i]) begin n_bad++; $display("FAIL ptrwrap%0d got %0d exp %0d", i, ts_data4, exp4[i]); end
            ready4 = 1; step(); ready4 = 0;
        end
        n_cmp++; if (ts_valid4 !== 1'b0 || overflow4 !== 1'b0) begin n_bad++; $display("FAIL wrap_end valid %b ovf %b exp 0 0", ts_valid4, overflow4); end
    endtask

    task automatic test_backpressure();
        logic [15:0] q[$];
        logic        m_ovf;
        logic        psh, pp;
        int          burst;
        do_reset();
        m_ovf = 0; burst = 0;
        for (int i = 0; i < 400; i++) begin
            if (burst == 0) burst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -int'($urandom_range(1, 6));
            detect = (burst > 0);
            burst = (burst > 0) ? burst - 1 : burst + 1;
            ts_ready = ($urandom_range(0, 2) != 0);
            n_cmp++; if (count !== 4'(q.size()) || ts_valid !== (q.size() != 0)) begin
                n_bad++; $display("FAIL bp_count%0d got %0d/%b exp %0d", i, count, ts_valid, q.size());
            end
            pp = ts_ready && (q.size() != 0);
            psh = detect && (q.size() < 8);
            if (detect && q.size() == 8) m_ovf = 1;
            if (pp) begin
                n_cmp++; if (ts_data !== q[0]) begin n_bad++; $display("FAIL bp_data%0d got %0d exp %0d", i, ts_data, q[0]); end
                void'(q.pop_front());
            end
            if (psh) q.push_back(m_ts);
            step();
        end
        detect = 0; ts_ready = 0;
        n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL bp_ovf got %b exp %b", overflow, m_ovf); end
    endtask

    initial begin
        m_ts = 16'd0;
        test_reset();
        test_fill_overflow();
        test_stream();
        test_wrap();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
